// File: rtl/multicycle_controller.sv
// Moore main control FSM for the multi-cycle RV32I core: sequences fetch/decode/execute/mem/writeback.
// Outputs decoded from state (mem handshake gates irwrite/pcwrite/mem_req); memory states wait on mem_ready with timeout.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] resultsrc,
  output logic [2:0] immsrc,
  output logic       illegal_instr,
  output logic       bus_error,
  output logic       instr_retired
);

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
    S_EXECUTER, S_EXECUTEI, S_AUIPC, S_JAL, S_ALUWB, S_LUIWB, S_BEQ, S_ILLEGAL
  } state_t;

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            in_mem;
  logic            timeout;

  assign in_mem  = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  assign timeout = (MEM_TIMEOUT != 0) && in_mem && !mem_ready && (cnt_q == TO_LIM);
  // Counter is zero in every non-memory state, so entering a memory state always starts from 0.
  assign cnt_d   = (in_mem && !mem_ready && !timeout) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    adrsrc        = 1'b0;
    memwrite      = 1'b0;
    irwrite       = 1'b0;
    pcwrite       = 1'b0;
    regwrite      = 1'b0;
    alusrca       = 2'b00;
    alusrcb       = 2'b00;
    aluop         = 2'b00;
    resultsrc     = 2'b00;
    illegal_instr = 1'b0;
    bus_error     = timeout;
    instr_retired = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req   = !timeout;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irwrite   = mem_ready;
        pcwrite   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
        else if (timeout) state_d = S_FETCH;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          OP_LUI:       state_d = S_LUIWB;
          OP_AUIPC:     state_d = S_AUIPC;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = !timeout;
        adrsrc  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
        else if (timeout) state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req       = !timeout;
        adrsrc        = 1'b1;
        memwrite      = !timeout;
        instr_retired = mem_ready;
        if (mem_ready || timeout) state_d = S_FETCH;
      end
      S_MEMWB: begin
        resultsrc     = 2'b01;
        regwrite      = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_EXECUTER: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        state_d = S_ALUWB;
      end
      S_JAL: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
        pcwrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB, S_LUIWB: begin
        resultsrc     = (state_q == S_LUIWB) ? 2'b11 : 2'b00;
        regwrite      = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_BEQ: begin
        alusrca       = 2'b10;
        aluop         = 2'b01;
        pcwrite       = zero;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal_instr = 1'b1;
        state_d       = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    immsrc = 3'b000;
    if ((state_q != S_IDLE) && (state_q != S_FETCH)) begin
      case (op)
        OP_SW:           immsrc = 3'b001;
        OP_BEQ:          immsrc = 3'b010;
        OP_JAL:          immsrc = 3'b011;
        OP_LUI, OP_AUIPC: immsrc = 3'b100;
        default:         immsrc = 3'b000;
      endcase
    end
  end

endmodule
